// File: rtl/io_interface_ram_slave.sv
// IO task responder backed by a word-organised RAM with configurable wait states.
// Define IO_SLAVE_ABORT_EN to abort a task when taskValid drops during WAIT.
module io_interface_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        taskValid,
  input  logic [31:0] address,
  input  logic        rwCtrl,
  input  logic [1:0]  widthCtr,
  input  logic [31:0] writeBus,
  output logic        taskReady,
  output logic        taskError,
  output logic [31:0] readBus
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [1:0]  width_q, width_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            in_idle, abort, go_done, task_err, misalign, range_err;
  logic [31:0]     t_addr, t_wdata, offset, wr_data, rd_raw, rd_val;
  logic            t_rw;
  logic [1:0]      t_width;
  logic [IdxW-1:0] word_idx;
  logic [4:0]      lane_sh;
  logic [3:0]      be;

  // With zero wait states the task completes on its acceptance edge, so use live inputs then.
  assign in_idle = (state_q == StIdle);
  assign t_addr  = in_idle ? address  : addr_q;
  assign t_wdata = in_idle ? writeBus : wdata_q;
  assign t_rw    = in_idle ? rwCtrl   : rw_q;
  assign t_width = in_idle ? widthCtr : width_q;

  assign offset    = t_addr - BASE_ADDR;
  assign word_idx  = offset[IdxW+1:2];
  assign range_err = (t_addr < BASE_ADDR) || (offset >= SpanBytes);
  assign misalign  = ((t_width == 2'b01) && t_addr[0]) ||
                     ((t_width == 2'b10) && (t_addr[1:0] != 2'b00));
  assign task_err  = range_err || misalign || (t_width == 2'b11);
  assign lane_sh   = {t_addr[1:0], 3'b000};
  assign wr_data   = t_wdata << lane_sh;
  assign rd_raw    = mem[word_idx] >> lane_sh;

`ifdef IO_SLAVE_ABORT_EN
  assign abort = (state_q == StWait) && !taskValid;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    be     = 4'b1111;
    rd_val = rd_raw;
    case (t_width)
      2'b00: begin
        be     = 4'b0001 << t_addr[1:0];
        rd_val = {24'h0, rd_raw[7:0]};
      end
      2'b01: begin
        be     = 4'b0011 << t_addr[1:0];
        rd_val = {16'h0, rd_raw[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (taskValid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (abort)               state_d = StIdle;
        else if (cnt_q == 4'd0)  state_d = StDone;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    go_done = (state_d == StDone) && (state_q != StDone);
    ready_d = go_done;
    error_d = go_done && task_err;
    rdata_d = (go_done && !task_err && !t_rw) ? rd_val : 32'h0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    width_d = width_q;
    if (in_idle && taskValid) begin
      addr_d  = address;
      wdata_d = writeBus;
      rw_d    = rwCtrl;
      width_d = widthCtr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rw_q    <= 1'b0;
      width_q <= 2'b00;
    end else begin
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      width_q <= width_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && go_done && t_rw && !task_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign taskReady = ready_q;
  assign taskError = error_q;
  assign readBus   = rdata_q;

endmodule

// File: tb/tb_io_interface_ram_slave.sv
// Bench for io_interface_ram_slave: a zero-wait and a three-wait instance against a
// byte-array reference model.
module tb_io_interface_ram_slave;

  localparam logic [31:0] BaseF  = 32'h0000_0000;
  localparam logic [31:0] BaseS  = 32'h0000_1000;
  localparam int unsigned Depth  = 16;
  localparam int unsigned Span   = Depth * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        f_valid, f_rw, f_ready, f_err;
  logic [1:0]  f_width;
  logic [31:0] f_addr, f_wdata, f_rdata;
  logic        s_valid, s_rw, s_ready, s_err;
  logic [1:0]  s_width;
  logic [31:0] s_addr, s_wdata, s_rdata;

  io_interface_ram_slave #(.BASE_ADDR(BaseF), .DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst), .taskValid(f_valid), .address(f_addr), .rwCtrl(f_rw),
    .widthCtr(f_width), .writeBus(f_wdata), .taskReady(f_ready), .taskError(f_err),
    .readBus(f_rdata)
  );

  io_interface_ram_slave #(.BASE_ADDR(BaseS), .DEPTH_WORDS(Depth), .WAIT_CYCLES(3)) u_slow (
    .clk(clk), .rst(rst), .taskValid(s_valid), .address(s_addr), .rwCtrl(s_rw),
    .widthCtr(s_width), .writeBus(s_wdata), .taskReady(s_ready), .taskError(s_err),
    .readBus(s_rdata)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mb [2][Span];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input logic v, input logic rw, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s) begin
      s_valid = v; s_rw = rw; s_width = w; s_addr = a; s_wdata = wd;
    end else begin
      f_valid = v; f_rw = rw; f_width = w; f_addr = a; f_wdata = wd;
    end
  endtask

  // Reference: byte-addressed memory and error rules in plain arithmetic.
  task automatic model_op(input bit s, input logic rw, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd);
    longint unsigned base, aa;
    int size, off;
    base = s ? 64'(BaseS) : 64'(BaseF);
    aa   = 64'(a);
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
    rd   = 32'h0;
    err  = 1'b0;
    if (size == 0) err = 1'b1;
    else if (aa < base || aa >= base + Span) err = 1'b1;
    else if ((aa % size) != 0) err = 1'b1;
    if (!err) begin
      off = int'(aa - base);
      for (int i = 0; i < size; i++) begin
        if (rw) mb[s][off+i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = mb[s][off+i];
      end
    end
  endtask

  task automatic run_task(input bit s, input logic rw, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] wd, input bit drop,
                          output bit got, output int lat, output logic err_o,
                          output logic [31:0] rd_o);
    logic rdy, e;
    logic [31:0] r;
    got = 1'b0; lat = -1; err_o = 1'b0; rd_o = 32'h0;
    @(negedge clk);
    drive(s, 1'b1, rw, w, a, wd);
    for (int k = 0; k < 12 && !got; k++) begin
      @(posedge clk); #1;
      rdy = s ? s_ready : f_ready;
      e   = s ? s_err   : f_err;
      r   = s ? s_rdata : f_rdata;
      if (rdy) begin
        got = 1'b1; lat = k; err_o = e; rd_o = r;
      end else begin
        check("quiet_out", {31'h0, e} | r, 32'h0);
      end
      @(negedge clk);
      if (drop || got) drive(s, 1'b0, rw, w, a, wd);
    end
    drive(s, 1'b0, rw, w, a, wd);
    if (got) begin
      @(posedge clk); #1;
      check("pulse_width", {31'h0, s ? s_ready : f_ready}, 32'h0);
      check("rd_after", s ? s_rdata : f_rdata, 32'h0);
    end
  endtask

  task automatic do_op(input bit s, input logic rw, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
    bit got;
    int lat;
    logic e, me;
    logic [31:0] r, mr;
    run_task(s, rw, w, a, wd, 1'b0, got, lat, e, r);
    model_op(s, rw, w, a, wd, me, mr);
    check({tag, "_rdy"}, {31'h0, got}, 32'h1);
    check({tag, "_lat"}, lat, s ? 32'd3 : 32'd0);
    check({tag, "_err"}, {31'h0, e}, {31'h0, me});
    check({tag, "_rd"}, r, mr);
  endtask

  initial begin
    bit got;
    int lat;
    logic e, me;
    logic [31:0] r, mr, a;
    logic [1:0] w;
    bit s;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_flags", {28'h0, f_ready, f_err, s_ready, s_err}, 32'h0);
      check("idle_rd", f_rdata | s_rdata, 32'h0);
    end

    for (int si = 0; si < 2; si++) begin
      for (int wi = 0; wi < int'(Depth); wi++) begin
        do_op(si[0], 1'b1, 2'd2, (si == 1 ? BaseS : BaseF) + 32'(4 * wi), $urandom, "init");
      end
    end

    do_op(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, "wr_word");
    do_op(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, "rd_word");
    check("rd_deadbeef", {mb[0][19], mb[0][18], mb[0][17], mb[0][16]}, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 2'd2, 32'h10, 32'h0, "clr_word");
    do_op(1'b0, 1'b1, 2'd0, 32'h11, 32'h0000_00A5, "wr_byte");
    do_op(1'b0, 1'b0, 2'd1, 32'h10, 32'h0, "rd_half");
    do_op(1'b0, 1'b0, 2'd0, 32'h13, 32'h0, "rd_byte");
    do_op(1'b0, 1'b0, 2'd2, 32'h12, 32'h0, "misalign");
    do_op(1'b0, 1'b1, 2'd2, BaseF + Span, 32'h5555_AAAA, "oob_wr");
    do_op(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, "rd_w0");
    do_op(1'b0, 1'b0, 2'd3, 32'h4, 32'h0, "width11");
    do_op(1'b1, 1'b0, 2'd2, BaseS - 4, 32'h0, "below_base");
    do_op(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0, "high_addr");
    do_op(1'b1, 1'b0, 2'd2, BaseS + Span - 4, 32'h0, "last_word");

    // Reset lands two edges after acceptance on the slow instance.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd2, BaseS + 32'h20, 32'hAAAA_5555);
    @(posedge clk); #1;
    check("rst_n0", {31'h0, s_ready}, 32'h0);
    @(posedge clk); #1;
    check("rst_n1", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_n2", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_quiet", {31'h0, s_ready}, 32'h0);
    end
    do_op(1'b1, 1'b0, 2'd2, BaseS + 32'h20, 32'h0, "rst_nowrite");
    do_op(1'b1, 1'b1, 2'd2, BaseS + 32'h24, 32'h0BAD_F00D, "post_rst");

    run_task(1'b1, 1'b1, 2'd2, BaseS + 32'h8, 32'h1234_5678, 1'b1, got, lat, e, r);
`ifdef IO_SLAVE_ABORT_EN
    check("abort_rdy", {31'h0, got}, 32'h0);
`else
    model_op(1'b1, 1'b1, 2'd2, BaseS + 32'h8, 32'h1234_5678, me, mr);
    check("noabort_rdy", {31'h0, got}, 32'h1);
    check("noabort_lat", lat, 32'd3);
    check("noabort_err", {31'h0, e}, {31'h0, me});
`endif
    do_op(1'b1, 1'b0, 2'd2, BaseS + 32'h8, 32'h0, "abort_rd");

    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom_range(0, 1));
      w = 2'($urandom_range(0, 3));
      a = (s ? BaseS - 8 : BaseF) + 32'($urandom_range(0, Span + 7));
      if ($urandom_range(0, 1) == 1) a = (w == 2'd2) ? {a[31:2], 2'b00} :
                                         (w == 2'd1) ? {a[31:1], 1'b0} : a;
      do_op(s, 1'($urandom_range(0, 1)), w, a, $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
